// File: rtl/mem_arb_interface.sv
// Multi-port arbiter in front of one single-port synchronous RAM, with byte-strobe writes.
// Define MEM_ARB_RSP_REG_EN to add a second response register stage (latency 2 instead of 1).
module mem_arb_interface #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 10,
  parameter int NUM_PORTS = 2,
  parameter int ARB_MODE  = 0
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [NUM_PORTS-1:0]              req_valid,
  output logic [NUM_PORTS-1:0]              req_ready,
  input  logic [NUM_PORTS-1:0]              req_write,
  input  logic [NUM_PORTS*DataWidth/8-1:0]  req_strb,
  input  logic [NUM_PORTS*AddrWidth-1:0]    req_addr,
  input  logic [NUM_PORTS*DataWidth-1:0]    req_wdata,
  output logic [NUM_PORTS-1:0]              rsp_valid,
  output logic [NUM_PORTS*DataWidth-1:0]    rsp_rdata
);

  localparam int NB    = DataWidth / 8;
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int DEPTH = 2 ** AddrWidth;

  logic [PW-1:0]          ptr_q, ptr_d, gnt_idx;
  logic [NUM_PORTS-1:0]   gnt;
  logic                   gnt_any, acc;
  logic                   sel_write;
  logic [NB-1:0]          sel_strb;
  logic [AddrWidth-1:0]   sel_addr;
  logic [DataWidth-1:0]   sel_wdata;

  logic [DataWidth-1:0]   mem_q [DEPTH];
  logic [DataWidth-1:0]   s1_data_q;
  logic                   s1_vld_q, s1_rd_q;
  logic [PW-1:0]          s1_port_q;

  logic                   out_vld, out_rd;
  logic [PW-1:0]          out_port;
  logic [DataWidth-1:0]   out_data;
  logic [NUM_PORTS*DataWidth-1:0] hold_q;

  // Fixed priority is round-robin with the search always starting at port 0.
  always_comb begin
    int start;
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    start   = (ARB_MODE == 1) ? 0 : int'(ptr_q);
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = start + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!gnt_any && req_valid[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

  assign ptr_d     = (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + PW'(1);
  assign acc       = gnt_any & reset_n;
  assign req_ready = gnt & {NUM_PORTS{reset_n}};

  assign sel_write = req_write[gnt_idx];
  assign sel_strb  = req_strb[gnt_idx*NB +: NB];
  assign sel_addr  = req_addr[gnt_idx*AddrWidth +: AddrWidth];
  assign sel_wdata = req_wdata[gnt_idx*DataWidth +: DataWidth];

  // RAM array and its read register carry no reset; acc is already gated by reset_n.
  always_ff @(posedge clock) begin
    if (acc) begin
      if (sel_write) begin
        for (int b = 0; b < NB; b++) begin
          if (sel_strb[b]) mem_q[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
        end
      end else begin
        s1_data_q <= mem_q[sel_addr];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_rd_q   <= 1'b0;
      s1_port_q <= '0;
    end else begin
      if (gnt_any) ptr_q <= ptr_d;
      s1_vld_q <= acc;
      if (acc) begin
        s1_port_q <= gnt_idx;
        s1_rd_q   <= ~sel_write;
      end
    end
  end

`ifdef MEM_ARB_RSP_REG_EN
  logic                 s2_vld_q, s2_rd_q;
  logic [PW-1:0]        s2_port_q;
  logic [DataWidth-1:0] s2_data_q;

  always_ff @(posedge clock) begin
    if (s1_vld_q && s1_rd_q) s2_data_q <= s1_data_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_vld_q  <= 1'b0;
      s2_rd_q   <= 1'b0;
      s2_port_q <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_port_q <= s1_port_q;
        s2_rd_q   <= s1_rd_q;
      end
    end
  end

  assign out_vld  = s2_vld_q;
  assign out_rd   = s2_rd_q;
  assign out_port = s2_port_q;
  assign out_data = s2_data_q;
`else
  assign out_vld  = s1_vld_q;
  assign out_rd   = s1_rd_q;
  assign out_port = s1_port_q;
  assign out_data = s1_data_q;
`endif

  // Per-port copy of the last read data so idle slices hold their value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else if (out_vld && out_rd) begin
      hold_q[out_port*DataWidth +: DataWidth] <= out_data;
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_rdata = hold_q;
    if (out_vld) begin
      rsp_valid[out_port] = 1'b1;
      if (out_rd) rsp_rdata[out_port*DataWidth +: DataWidth] = out_data;
    end
  end

endmodule

// File: tb/tb_mem_arb_interface.sv
// Directed bench for mem_arb_interface: vector table plus hand sequences for
// hazards, back-to-back reads, arbitration and reset mid-operation.
module tb_mem_arb_interface;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NP = 2;
`ifdef MEM_ARB_RSP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [NP-1:0]      req_valid, req_ready, req_write, rsp_valid;
  logic [NP-1:0]      fp_ready, fp_rsp_valid;
  logic [NP*DW/8-1:0] req_strb;
  logic [NP*AW-1:0]   req_addr;
  logic [NP*DW-1:0]   req_wdata, rsp_rdata, fp_rsp_rdata;

  always #5 clock = ~clock;

  mem_arb_interface #(.DataWidth(DW), .AddrWidth(AW), .NUM_PORTS(NP), .ARB_MODE(0)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_strb(req_strb), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata));

  mem_arb_interface #(.DataWidth(DW), .AddrWidth(AW), .NUM_PORTS(NP), .ARB_MODE(1)) u_fp (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(fp_ready),
    .req_write(req_write), .req_strb(req_strb), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(fp_rsp_valid), .rsp_rdata(fp_rsp_rdata));

  typedef struct {
    int             port;
    logic           wr;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [3:0]     strb;
    logic [DW-1:0]  exp;
  } vec_t;

  vec_t          vecs [12];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] last_rd [NP];

  function automatic logic [DW-1:0] bb(input int i);
    return 32'hC0DE0000 + 32'(i) * 32'h00000111;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_write = '0; req_strb = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic set_port(input int p, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [3:0] s);
    req_valid[p]          = 1'b1;
    req_write[p]          = wr;
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*DW +: DW] = d;
    req_strb[p*4 +: 4]    = s;
  endtask

  task automatic chk_rsp(input string name, input int p, input logic rd, input logic [DW-1:0] exp);
    chk({name, " rsp_valid"}, 64'(rsp_valid), 64'(1) << p);
    if (rd) last_rd[p] = exp;
    chk({name, " rsp_rdata"}, rsp_rdata, {last_rd[1], last_rd[0]});
  endtask

  task automatic do_txn(input string name, input int p, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] s, input logic [DW-1:0] exp);
    @(negedge clock);
    set_port(p, wr, a, d, s);
    #1;
    chk({name, " req_ready"}, 64'(req_ready), 64'(1) << p);
    @(posedge clock); #1;
    idle_inputs();
    for (int i = 1; i < LAT; i++) begin
      chk({name, " early rsp"}, 64'(rsp_valid), 64'(0));
      @(posedge clock); #1;
    end
    chk_rsp(name, p, !wr, exp);
    @(posedge clock); #1;
    chk({name, " rsp pulse"}, 64'(rsp_valid), 64'(0));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1]  = '{0, 1'b0, 10'h005, 32'h0,        4'h0, 32'hDEADBEEF};
    vecs[2]  = '{0, 1'b1, 10'h010, 32'h11223344, 4'hF, 32'h0};
    vecs[3]  = '{1, 1'b1, 10'h010, 32'hAABBCCDD, 4'h5, 32'h0};
    vecs[4]  = '{0, 1'b0, 10'h010, 32'h0,        4'h0, 32'h11BB33DD};
    vecs[5]  = '{1, 1'b1, 10'h010, 32'hFFFFFFFF, 4'h0, 32'h0};
    vecs[6]  = '{1, 1'b0, 10'h010, 32'h0,        4'h0, 32'h11BB33DD};
    vecs[7]  = '{1, 1'b1, 10'h3FF, 32'hCAFEF00D, 4'hF, 32'h0};
    vecs[8]  = '{0, 1'b0, 10'h3FF, 32'h0,        4'h0, 32'hCAFEF00D};
    vecs[9]  = '{0, 1'b1, 10'h000, 32'h00000000, 4'hF, 32'h0};
    vecs[10] = '{1, 1'b1, 10'h000, 32'h12345678, 4'hA, 32'h0};
    vecs[11] = '{0, 1'b0, 10'h000, 32'h0,        4'h0, 32'h12005600};

    // reset state
    idle_inputs();
    last_rd[0] = '0;
    last_rd[1] = '0;
    req_valid = 2'b11;
    #1;
    chk("reset req_ready", 64'(req_ready), 64'(0));
    chk("reset fp req_ready", 64'(fp_ready), 64'(0));
    chk("reset rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset rsp_rdata", rsp_rdata, 64'(0));
    do_reset();

    foreach (vecs[i])
      do_txn($sformatf("vec%0d", i), vecs[i].port, vecs[i].wr, vecs[i].addr,
             vecs[i].wdata, vecs[i].strb, vecs[i].exp);

    // write on port 1 immediately followed by a read of the same address on port 0
    @(negedge clock);
    set_port(1, 1'b1, 10'h020, 32'h5A5A1234, 4'hF);
    for (int c = 0; c <= LAT + 1; c++) begin
      @(posedge clock); #1;
      idle_inputs();
      if (c == 0) begin
        set_port(0, 1'b0, 10'h020, 32'h0, 4'h0);
        #1;
        chk("hazard read ready", 64'(req_ready), 64'(2'b01));
      end
      chk($sformatf("hazard rsp_valid c%0d", c), 64'(rsp_valid),
          (c == LAT - 1) ? 64'(2'b10) : (c == LAT) ? 64'(2'b01) : 64'(0));
      if (c == LAT) begin
        last_rd[0] = 32'h5A5A1234;
        chk("hazard rdata", rsp_rdata, {last_rd[1], last_rd[0]});
      end
    end

    // preload and back-to-back reads on port 0
    for (int i = 0; i < 8; i++)
      do_txn($sformatf("preload%0d", i), 0, 1'b1, AW'(i), bb(i), 4'hF, 32'h0);
    @(negedge clock);
    set_port(0, 1'b0, 10'h000, 32'h0, 4'h0);
    for (int c = 0; c < 8 + LAT - 1; c++) begin
      @(posedge clock); #1;
      if (c - LAT + 1 >= 0) begin
        last_rd[0] = bb(c - LAT + 1);
        chk($sformatf("b2b%0d rsp_valid", c - LAT + 1), 64'(rsp_valid), 64'(2'b01));
        chk($sformatf("b2b%0d rdata", c - LAT + 1), rsp_rdata, {last_rd[1], last_rd[0]});
      end
      if (c < 7) req_addr[AW-1:0] = AW'(c + 1);
      else idle_inputs();
    end
    @(posedge clock); #1;
    chk("b2b trailing", 64'(rsp_valid), 64'(0));

    // arbitration: both ports valid for 6 cycles right after reset
    do_reset();
    @(negedge clock);
    set_port(0, 1'b0, 10'h001, 32'h0, 4'h0);
    set_port(1, 1'b0, 10'h002, 32'h0, 4'h0);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rr grant%0d", c), 64'(req_ready), (c % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      chk($sformatf("fp grant%0d", c), 64'(fp_ready), 64'(2'b01));
      @(posedge clock);
    end
    #1;
    idle_inputs();
    repeat (LAT + 1) @(posedge clock);
    #1;
    last_rd[0] = bb(1);
    last_rd[1] = bb(2);
    chk("rr final rdata", rsp_rdata, {last_rd[1], last_rd[0]});

    // reset while a read response is pending; a write is held valid during reset
    @(negedge clock);
    set_port(0, 1'b0, 10'h005, 32'h0, 4'h0);
    @(posedge clock); #1;
    idle_inputs();
    reset_n = 1'b0;
    set_port(0, 1'b1, 10'h005, 32'h0, 4'hF);
    #1;
    chk("midrst rsp_valid", 64'(rsp_valid), 64'(0));
    chk("midrst rsp_rdata", rsp_rdata, 64'(0));
    chk("midrst req_ready", 64'(req_ready), 64'(0));
    repeat (2) @(posedge clock);
    #1;
    chk("midrst held rsp_valid", 64'(rsp_valid), 64'(0));
    idle_inputs();
    @(negedge clock);
    reset_n = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    for (int c = 0; c <= LAT; c++) begin
      @(posedge clock); #1;
      chk($sformatf("postrst rsp_valid%0d", c), 64'(rsp_valid), 64'(0));
    end
    @(negedge clock);
    set_port(0, 1'b0, 10'h001, 32'h0, 4'h0);
    set_port(1, 1'b0, 10'h002, 32'h0, 4'h0);
    #1;
    chk("postrst pointer", 64'(req_ready), 64'(2'b01));
    idle_inputs();
    do_txn("postrst ram", 1, 1'b0, 10'h005, 32'h0, 4'h0, bb(5));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
